// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the flagged synchronous FIFO:
//   - READ / WRITE / BOTH : encodings of the accepted-access pair {wr, rd}
//   - fifo_status_t       : registered occupancy flags
//   - fifo_ptr_inc()      : circular pointer increment for any depth
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  // Accepted access this cycle, encoded as {write, read}.
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] BOTH  = 2'b11;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Next pointer value with wrap at depth-1 -> 0. For a power-of-two depth
  // the wrap is just the natural roll-over of the increment (masked here);
  // otherwise an explicit terminal-count compare is needed.
  function automatic int unsigned fifo_ptr_inc(input int unsigned ptr,
                                                input int unsigned depth);
    if ((depth & (depth - 1)) == 0)
      return (ptr + 1) & (depth - 1);
    else if (ptr == depth - 1)
      return 0;
    else
      return ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Storage array for sync_fifo_flagged. One synchronous write port and one
// read port that is either combinational (FWFT=1) or registered (FWFT=0).
// Contents are never reset; only the registered read word is.
//   clk_i, rst_n_i  : clock, async active-low reset (registered read only)
//   wr_en_i         : write wr_data_i to wr_addr_i at the rising edge
//   rd_en_i         : registered mode: capture mem[rd_addr_i] at the edge
//   rd_addr_i       : read address (head pointer)
//   rd_data_o       : read word
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter bit FWFT       = 1'b1,
  parameter int PW         = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [PW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [PW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  if (FWFT) begin : g_fwft
    // Head word visible without a read strobe; reset and enable unneeded.
    logic unused_rd_ctl;
    assign unused_rd_ctl = ^{rst_n_i, rd_en_i};
    assign rd_data_o     = mem_q[rd_addr_i];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    // A simultaneous write to the same slot (full FIFO, write+read) returns
    // the old word: the array update and this capture share the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end
    assign rd_data_o = rd_data_q;
  end

endmodule

// File: rtl/sync_fifo_flagged.sv
// -----------------------------------------------------------------------------
// sync_fifo_flagged
// Single-clock circular-buffer FIFO with occupancy count, almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and synchronous
// flush. Depth may be any value >= 2, including non-powers-of-two.
//   clk_i, rst_n_i   : clock, async active-low reset
//   flush_i          : synchronous clear of contents (beats read/write)
//   write_i/wr_data_i: write request and word
//   read_i           : read request
//   rd_data_o        : FWFT=1 head word; FWFT=0 word from last accepted read
//   rd_valid_o       : FWFT=1 !empty; FWFT=0 one-cycle pulse after a read
//   full_o/empty_o/almost_full_o/almost_empty_o/count_o : registered status
//   overflow_o/underflow_o : sticky error flags, cleared by err_clr_i
// -----------------------------------------------------------------------------
module sync_fifo_flagged
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter bit FWFT       = 1'b1,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              flush_i,
  input  logic                              write_i,
  input  logic [DATA_WIDTH-1:0]             wr_data_i,
  input  logic                              read_i,
  output logic [DATA_WIDTH-1:0]             rd_data_o,
  output logic                              rd_valid_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              almost_full_o,
  output logic                              almost_empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              overflow_o,
  output logic                              underflow_o,
  input  logic                              err_clr_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Flag values for an empty FIFO; shared by reset and flush.
  localparam fifo_status_t STAT_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  (AF_THRESH == 0),
    almost_empty: 1'b1
  };

  if (FIFO_DEPTH < 2 || AF_THRESH > FIFO_DEPTH || AE_THRESH >= FIFO_DEPTH)
  begin : g_bad_param
    $error("sync_fifo_flagged: need FIFO_DEPTH>=2, AF_THRESH<=FIFO_DEPTH, AE_THRESH<FIFO_DEPTH");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  fifo_status_t  stat_q,   stat_d;
  logic          ovf_q,    ovf_d;
  logic          unf_q,    unf_d;

  logic rd_acc, wr_acc;   // acceptance as seen by the error logic
  logic rd_do,  wr_do;    // acceptance that actually moves state (no flush)

  // A full FIFO still takes a write when a read frees the head slot.
  assign rd_acc = read_i  & ~stat_q.empty;
  assign wr_acc = write_i & (~stat_q.full | rd_acc);
  assign rd_do  = rd_acc & ~flush_i;
  assign wr_do  = wr_acc & ~flush_i;

  // ---------------------------------------------------------------------------
  // Next-state: pointers, count, and status flags derived from next count so
  // the registered flags line up with the post-edge occupancy.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_do) wr_ptr_d = PW'(fifo_ptr_inc(32'(wr_ptr_q), FIFO_DEPTH));
      if (rd_do) rd_ptr_d = PW'(fifo_ptr_inc(32'(rd_ptr_q), FIFO_DEPTH));
      case ({wr_do, rd_do})
        WRITE:   count_d = count_q + CW'(1);
        READ:    count_d = count_q - CW'(1);
        default: count_d = count_q;   // BOTH or idle: occupancy unchanged
      endcase
    end

    stat_d.full         = (count_d == DEPTH_C);
    stat_d.empty        = (count_d == '0);
    stat_d.almost_full  = (count_d >= AF_C);
    stat_d.almost_empty = (count_d <= AE_C);
  end

  // Sticky errors: a new event in the same cycle as err_clr_i survives.
  // Flush does not touch them, and they track requests even under flush.
  assign ovf_d = (ovf_q & ~err_clr_i) | (write_i & stat_q.full & ~rd_acc);
  assign unf_d = (unf_q & ~err_clr_i) | (read_i & stat_q.empty);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stat_q   <= STAT_RST;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stat_q   <= stat_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FWFT       (FWFT),
    .PW         (PW)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (wr_do),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_do),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data_o)
  );

  // ---------------------------------------------------------------------------
  // Read-valid
  // ---------------------------------------------------------------------------
  if (FWFT) begin : g_vld_fwft
    assign rd_valid_o = ~stat_q.empty;
  end else begin : g_vld_std
    // One-cycle pulse accompanying the word captured by an accepted read;
    // flush suppresses rd_do, so it also drops the pulse.
    logic rd_vld_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rd_vld_q <= 1'b0;
      else          rd_vld_q <= rd_do;
    end
    assign rd_valid_o = rd_vld_q;
  end

  assign full_o         = stat_q.full;
  assign empty_o        = stat_q.empty;
  assign almost_full_o  = stat_q.almost_full;
  assign almost_empty_o = stat_q.almost_empty;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
- Next-generation synchronous FIFO: a circular buffer with parametrised data width and depth, including non-power-of-two depths.
- Selectable FWFT or standard read mode.
- Adds what the previous buffer lacked: occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between producer and consumer stages in the same clock domain.

Parameters:
DATA_WIDTH, 32, bits per word
FIFO_DEPTH, 32, words stored; any value >= 2
FWFT, 1, 1 = head word visible combinationally on rd_data_o; 0 = registered read, one cycle after accepted read
AF_THRESH, FIFO_DEPTH-2, almost_full_o asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty_o asserted when count <= AE_THRESH

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of contents
write_i  in  1  write request
wr_data_i  in  DATA_WIDTH  write word
read_i  in  1  read request
rd_data_o  out  DATA_WIDTH  read word
rd_valid_o  out  1  rd_data_o holds a valid word
full_o  out  1  count == FIFO_DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_THRESH
almost_empty_o  out  1  count <= AE_THRESH
count_o  out  $clog2(FIFO_DEPTH+1)  current occupancy
overflow_o  out  1  sticky: write attempted while full
underflow_o  out  1  sticky: read attempted while empty
err_clr_i  in  1  clears overflow_o/underflow_o

Behaviour:
- Reset values (async, rst_n_i low): pointers 0, count_o 0, empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0 (almost_full_o 1 only if AF_THRESH == 0), overflow_o 0, underflow_o 0, rd_valid_o 0, standard-mode rd_data_o 0. Memory contents are not reset.
- All status outputs are registered and computed from next-state count. They reflect the post-edge occupancy in the same cycle the pointers update.
- Acceptance:
  - wr_acc = write_i & (!full_o | rd_acc)
  - rd_acc = read_i & !empty_o
- Full with write+read: both accepted, count unchanged, memory written at wr_ptr while head is read.
- Empty with write+read: write accepted, read rejected, underflow_o set.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Pointer wrap: FIFO_DEPTH-1 -> 0. Use a plain increment when FIFO_DEPTH is a power of two, otherwise an explicit compare.
- Error flags:
  - overflow_o sets on write_i & full_o & !rd_acc.
  - underflow_o sets on read_i & empty_o.
  - Both hold until err_clr_i. If set and clear coincide, set wins.
- Flush:
  - flush_i has priority over read/write in the same cycle. Pointers and count go to 0, flags go to the reset values, and rd_valid_o deasserts.
  - Error flags are not cleared by flush.
- FWFT=1:
  - rd_data_o = mem[rd_ptr] combinationally; rd_valid_o = !empty_o.
  - A write into an empty FIFO appears on rd_data_o on the cycle after the write edge.
- FWFT=0:
  - On rd_acc, rd_data_o <= mem[rd_ptr] at the edge and rd_valid_o pulses high for exactly one cycle.
  - rd_data_o holds its value otherwise.
- Latency, write to readable: 1 cycle.
- Thresholds are checked at elaboration: AF_THRESH <= FIFO_DEPTH and AE_THRESH < FIFO_DEPTH, else $error.

Decomposition:
- Package sync_fifo_pkg:
  - access-mode constants: READ=2'b01, WRITE=2'b10, BOTH=2'b11
  - function fifo_ptr_inc(ptr, depth) for wrap handling
  - typedef for the status-flag struct: full, empty, almost_full, almost_empty
- One sub-module, sync_fifo_mem: dual-port array with a synchronous write port and a read port that is combinational or registered per FWFT.
- Controller (pointers, count, flags) stays in the top level.

Test Plan (DATA_WIDTH=8, FIFO_DEPTH=5, AF_THRESH=4, AE_THRESH=1, both FWFT values):
- Reset, then write 0x11..0x15 on 5 consecutive cycles:
  - count_o steps 1..5
  - almost_empty_o drops after the 2nd write, almost_full_o rises after the 4th, full_o rises after the 5th
  - a 6th write sets overflow_o, count_o stays 5
- Read 5 words from full:
  - data order is 0x11..0x15; FWFT shows 0x11 with no read latency, standard shows it 1 cycle after read_i
  - rd_ptr wraps 4 -> 0, empty_o rises after the 5th read
  - a further read sets underflow_o
- Simultaneous write+read at count=5: both accepted, count stays 5, no overflow, next read returns the oldest word.
- Simultaneous write+read at empty: write accepted, underflow_o set, count becomes 1.
- Fill to 3, then flush_i together with write_i:
  - next cycle count_o=0, empty_o=1, rd_valid_o=0, written word discarded
  - overflow_o/underflow_o unchanged; err_clr_i then clears them
- Assert rst_n_i low mid-stream at count=3, asynchronously between edges: all outputs take reset values immediately, with no clock edge.
